// File: rtl/dcache_fill_if.sv
`default_nettype none
// ============================================================================
// dcache_fill_if : miss/memory/array signal bundle for the D-cache fill FSM
// Revision 1.0
// ============================================================================
interface dcache_fill_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int BLOCK_WORDS = 8
);
  localparam int SEL_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

  logic                  miss_detected;
  logic [ADDR_WIDTH-1:0] miss_address;
  logic                  memory_data_valid;
  logic [15:0]           memory_data;
  logic                  fsm_busy;
  logic                  mem_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  write_data_array;
  logic                  write_tag_array;
  logic [SEL_W-1:0]      array_word_sel;
  logic [15:0]           array_data;

  modport master (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output fsm_busy, mem_en, mem_addr, write_data_array, write_tag_array,
           array_word_sel, array_data
  );

  modport slave (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  fsm_busy, mem_en, mem_addr, write_data_array, write_tag_array,
           array_word_sel, array_data
  );
endinterface
`default_nettype wire

// File: rtl/dcache_fill_fsm.sv
`default_nettype none
// ============================================================================
// dcache_fill_fsm : fetches a whole block on a D-cache miss, tag written last
// Revision 1.0
// ============================================================================
module dcache_fill_fsm #(
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_WIDTH  = 16
) (
  input  wire            clk,
  input  wire            rst,
  dcache_fill_if.master  bus
);
  localparam int CW    = $clog2(BLOCK_WORDS) + 1;
  localparam int SEL_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;

  localparam logic [CW-1:0]         c_bw         = CW'(BLOCK_WORDS);
  localparam logic [CW-1:0]         c_last       = CW'(BLOCK_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] c_align_mask = ~ADDR_WIDTH'(2 * BLOCK_WORDS - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_next_state;
  logic [CW-1:0]         r_issue_cnt;
  logic [CW-1:0]         r_recv_cnt;
  logic [ADDR_WIDTH-1:0] r_base;
  logic                  w_issue;
  logic                  w_write;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
      r_base      <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == IDLE) begin
        if (bus.miss_detected) begin
          r_base <= bus.miss_address & c_align_mask;
        end
        r_issue_cnt <= '0;
        r_recv_cnt  <= '0;
      end else begin
        // Request and response sides advance independently.
        if (w_issue) r_issue_cnt <= r_issue_cnt + CW'(1);
        if (w_write) r_recv_cnt  <= r_recv_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    w_next_state         = r_state;
    w_issue              = 1'b0;
    w_write              = 1'b0;
    bus.fsm_busy         = 1'b0;
    bus.mem_en           = 1'b0;
    bus.mem_addr         = '0;
    bus.write_data_array = 1'b0;
    bus.write_tag_array  = 1'b0;
    bus.array_word_sel   = '0;
    bus.array_data       = '0;

    case (r_state)
      IDLE: begin
        bus.fsm_busy = bus.miss_detected;
        if (bus.miss_detected) w_next_state = FILL;
      end
      FILL: begin
        bus.fsm_busy = 1'b1;
        w_issue      = (r_issue_cnt < c_bw);
        w_write      = bus.memory_data_valid && (r_recv_cnt < c_bw);
        if (w_issue) begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = r_base + (ADDR_WIDTH'(r_issue_cnt) << 1);
        end
        if (w_write) begin
          bus.write_data_array = 1'b1;
          bus.array_word_sel   = r_recv_cnt[SEL_W-1:0];
          bus.array_data       = bus.memory_data;
          // Final word: tag goes in alongside the last data write.
          if (r_recv_cnt == c_last) begin
            bus.write_tag_array = 1'b1;
            w_next_state        = IDLE;
          end
        end
      end
      default: w_next_state = IDLE;
    endcase
  end
endmodule
`default_nettype wire
